// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: sequencing controller for a 5-stage MIPS pipeline (IF/ID/EX/MEM/WB).
//   Owns the global stage enable, the PC and IF/ID write enables and the bubble/flush lines.
//   Detects load-use hazards and taken-branch flushes. Runs a debug run/step/halt/drain FSM
//   so that a halt request lets in-flight instructions retire through WB before stopping.
//
// Ports:
//   i_clk, i_reset          clock, synchronous active-high reset
//   i_dbg_run/step/halt     debug commands
//   i_halt_W                HALT instruction in WB
//   i_mem_read_E, i_rt_E    load in EX and its destination register
//   i_rs_D, i_rt_D          source registers of the instruction in ID
//   i_branch_taken_D        branch/jump resolved taken in ID
//   o_stage_en              global pipeline register enable
//   o_pc_write, o_if_id_write, o_if_id_flush, o_id_ex_flush  hazard controls
//   o_halted, o_done        FSM status
//   o_cycle_cnt             enabled-cycle count
//
// Optional feature: define PIPE_CYCLE_CNT_EN to build the enabled-cycle counter; otherwise
// o_cycle_cnt is tied to zero.
module pipeline_ctrl #(
  parameter int unsigned REG_ADDR_SZ = 5,
  parameter int unsigned PIPE_DEPTH  = 5,
  parameter int unsigned CNT_SZ      = 32
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_dbg_run,
  input  logic                   i_dbg_step,
  input  logic                   i_dbg_halt,
  input  logic                   i_halt_W,
  input  logic                   i_mem_read_E,
  input  logic [REG_ADDR_SZ-1:0] i_rt_E,
  input  logic [REG_ADDR_SZ-1:0] i_rs_D,
  input  logic [REG_ADDR_SZ-1:0] i_rt_D,
  input  logic                   i_branch_taken_D,
  output logic                   o_stage_en,
  output logic                   o_pc_write,
  output logic                   o_if_id_write,
  output logic                   o_if_id_flush,
  output logic                   o_id_ex_flush,
  output logic                   o_halted,
  output logic                   o_done,
  output logic [CNT_SZ-1:0]      o_cycle_cnt
);

  localparam int unsigned DrainW = $clog2(PIPE_DEPTH) + 1;
  localparam logic [DrainW-1:0] DrainLoad = DrainW'(PIPE_DEPTH - 1);

  typedef enum logic [2:0] {
    StHalted,
    StRun,
    StStep,
    StDrain,
    StDone
  } state_e;

  state_e            state_q, state_d;
  logic [DrainW-1:0] drain_q, drain_d;
  logic              stall;

  // Register 0 is hardwired zero, so a load targeting it never creates a dependency.
  assign stall = i_mem_read_E && (i_rt_E != '0) && ((i_rt_E == i_rs_D) || (i_rt_E == i_rt_D));

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= StHalted;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    drain_d       = drain_q;
    o_stage_en    = 1'b0;
    o_pc_write    = 1'b0;
    o_if_id_write = 1'b0;
    o_if_id_flush = 1'b0;
    o_id_ex_flush = 1'b0;
    o_halted      = 1'b0;
    o_done        = 1'b0;

    case (state_q)
      StHalted: begin
        o_halted = 1'b1;
        if (i_dbg_run) begin
          state_d = StRun;
        end else if (i_dbg_step) begin
          state_d = StStep;
        end
      end
      StRun, StStep: begin
        o_stage_en = 1'b1;
        // Stall masks the branch; the branch is seen again once the load has moved on.
        if (stall) begin
          o_id_ex_flush = 1'b1;
        end else begin
          o_pc_write    = 1'b1;
          o_if_id_write = 1'b1;
          o_if_id_flush = i_branch_taken_D;
        end
        if (i_halt_W) begin
          state_d = StDone;
        end else if (state_q == StStep) begin
          state_d = StHalted;
        end else if (i_dbg_halt) begin
          state_d = StDrain;
          drain_d = DrainLoad;
        end
      end
      StDrain: begin
        // Feed bubbles behind the in-flight instructions until they reach WB.
        o_stage_en    = 1'b1;
        o_if_id_write = 1'b1;
        o_if_id_flush = 1'b1;
        drain_d       = drain_q - DrainW'(1);
        if (i_halt_W) begin
          state_d = StDone;
        end else if (drain_q <= DrainW'(1)) begin
          state_d = StHalted;
        end
      end
      StDone: begin
        o_done = 1'b1;
      end
      default: begin
        state_d = StHalted;
        drain_d = '0;
      end
    endcase
  end

`ifdef PIPE_CYCLE_CNT_EN
  logic [CNT_SZ-1:0] cycle_cnt_q;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      cycle_cnt_q <= '0;
    end else if (o_stage_en) begin
      cycle_cnt_q <= cycle_cnt_q + CNT_SZ'(1);
    end
  end

  assign o_cycle_cnt = cycle_cnt_q;
`else
  assign o_cycle_cnt = '0;
`endif

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
Central sequencing controller for the 5-stage MIPS pipeline (IF/ID/EX/MEM/WB).
- Owns the global stage enable, PC/IF-ID write enables and flush lines.
- Detects load-use hazards and taken-branch flushes.
- Runs a debug run/step/halt/drain state machine, so the pipeline stops only after in-flight instructions have retired through WB.

Parameters:
REG_ADDR_SZ, 5, register file address width
PIPE_DEPTH, 5, pipeline stages; sets drain length (PIPE_DEPTH-1 cycles)
CNT_SZ, 32, cycle counter width (optional feature only)

Ports:
i_clk  input  1  system clock, rising edge
i_reset  input  1  synchronous, active-high reset
i_dbg_run  input  1  debug command: free-run
i_dbg_step  input  1  debug command: advance one cycle
i_dbg_halt  input  1  debug command: stop after draining
i_halt_W  input  1  HALT instruction present in WB stage
i_mem_read_E  input  1  MemRead control of instruction in EX
i_rt_E  input  REG_ADDR_SZ  rt (load destination) of instruction in EX
i_rs_D  input  REG_ADDR_SZ  rs of instruction in ID
i_rt_D  input  REG_ADDR_SZ  rt of instruction in ID
i_branch_taken_D  input  1  branch/jump resolved taken in ID
o_stage_en  output  1  global enable for all pipeline registers
o_pc_write  output  1  PC write enable
o_if_id_write  output  1  IF/ID register write enable
o_if_id_flush  output  1  load bubble into IF/ID
o_id_ex_flush  output  1  load bubble into ID/EX (control lines zeroed)
o_halted  output  1  FSM in HALTED
o_done  output  1  FSM in DONE
o_cycle_cnt  output  CNT_SZ  enabled-cycle count (PIPE_CYCLE_CNT_EN only; else tied 0)

Behaviour:
- Single clock domain, synchronous active-high reset.
- State and drain counter are registered. All other outputs are combinational from state plus hazard inputs; no added latency.
- Reset: state=HALTED, drain counter=0. Outputs: o_stage_en=0, o_pc_write=0, o_if_id_write=0, o_if_id_flush=0, o_id_ex_flush=0, o_halted=1, o_done=0, o_cycle_cnt=0.
- Reset wins over every other input in any state, including mid-DRAIN.
- States: HALTED, RUN, STEP, DRAIN, DONE. One transition per cycle.
- HALTED:
  - o_stage_en=0.
  - i_dbg_run -> RUN; else i_dbg_step -> STEP. Run has priority if both are set.
  - i_dbg_halt is ignored.
- RUN:
  - o_stage_en=1.
  - i_halt_W -> DONE; else i_dbg_halt -> DRAIN, loading counter with PIPE_DEPTH-1.
  - i_halt_W beats i_dbg_halt on the same cycle.
- STEP:
  - o_stage_en=1 for exactly one cycle.
  - Next state: DONE if i_halt_W, else HALTED.
- DRAIN:
  - o_stage_en=1, o_pc_write=0, o_if_id_write=1, o_if_id_flush=1: bubbles enter, older instructions advance to WB.
  - Counter decrements each cycle. In the cycle the counter reads 1 -> HALTED (PIPE_DEPTH-1 drain cycles total).
  - i_halt_W -> DONE immediately. Debug commands are ignored.
- DONE:
  - o_stage_en=0, o_done=1.
  - Exits only on reset.
- Hazard logic is active only in RUN and STEP. In HALTED and DONE, all write enables and flushes are 0.
- Load-use stall condition: i_mem_read_E=1, i_rt_E!=0, and (i_rt_E==i_rs_D or i_rt_E==i_rt_D). While stalled:
  - o_pc_write=0, o_if_id_write=0, o_id_ex_flush=1, o_if_id_flush=0.
- Stall has priority over branch: i_branch_taken_D is ignored that cycle and re-evaluated once the stall clears.
- Taken branch with no stall: o_if_id_flush=1; PC and IF/ID writes stay 1.
- No hazard, and state is RUN or STEP: o_pc_write=1, o_if_id_write=1, both flushes 0.
- Register 0 never causes a stall.

Optional Feature:
PIPE_CYCLE_CNT_EN
- Defined:
  - o_cycle_cnt increments by 1 on every cycle with o_stage_en=1, wrapping modulo 2^CNT_SZ.
  - Cleared only by reset; holds in HALTED and DONE.
- Undefined: no counter register; o_cycle_cnt driven constant 0.

Test Plan:
1. Reset, then pulse i_dbg_step -> exactly 1 cycle with o_stage_en=1, then o_halted=1. With PIPE_CYCLE_CNT_EN, o_cycle_cnt=1.
2. RUN; i_mem_read_E=1, i_rt_E=8, i_rs_D=8 for one cycle -> o_pc_write=0, o_if_id_write=0, o_id_ex_flush=1. Repeat with i_rt_E=0 -> no stall.
3. RUN; stall condition and i_branch_taken_D=1 in the same cycle -> stall outputs only, o_if_id_flush=0. Next cycle with no stall and branch still taken -> o_if_id_flush=1.
4. RUN; pulse i_dbg_halt -> 4 cycles with o_pc_write=0 and o_if_id_flush=1, then o_halted=1 and o_stage_en=0.
5. RUN; i_halt_W=1 -> o_done=1 next cycle; i_dbg_run is then ignored; i_reset=1 -> o_halted=1.
6. Assert i_reset during DRAIN with the counter at 2 -> next cycle HALTED, all enables 0, o_cycle_cnt=0.
